// File: rtl/demux_1to2.sv
// demux_1to2: 1-to-2 demultiplexer with registered outputs.
// Data input i is steered to y1 (s=0) or y2 (s=1) one clock later; the
// deselected output is driven to 0 and the y*_vld flags tell a routed zero
// apart from an idle zero.
// Optional feature macro: DEMUX_COUNT_EN adds saturating per-output route
// counters (cnt_y1, cnt_y2) and their synchronous clear input cnt_clr.
// Reset is synchronous and active-high.
module demux_1to2 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i,
  input  logic             s,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic             y1_vld,
`ifdef DEMUX_COUNT_EN
  output logic             y2_vld,
  output logic [CNT_W-1:0] cnt_y1,
  output logic [CNT_W-1:0] cnt_y2,
  input  logic             cnt_clr
`else
  output logic             y2_vld
`endif
);

  logic [WIDTH-1:0] y1_q, y1_d;
  logic [WIDTH-1:0] y2_q, y2_d;
  logic             y1_vld_q, y1_vld_d;
  logic             y2_vld_q, y2_vld_d;

  // Route the input to the selected side and force the other side to zero.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    y1_d     = '0;
    y2_d     = '0;
    y1_vld_d = 1'b0;
    y2_vld_d = 1'b0;
    if (s) begin
      y2_d     = i;
      y2_vld_d = 1'b1;
    end else begin
      y1_d     = i;
      y1_vld_d = 1'b1;
    end
  end

  // Output registers with synchronous reset overriding the routed data.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    if (rst) begin
      y1_q     <= '0;
      y2_q     <= '0;
      y1_vld_q <= 1'b0;
      y2_vld_q <= 1'b0;
    end else begin
      y1_q     <= y1_d;
      y2_q     <= y2_d;
      y1_vld_q <= y1_vld_d;
      y2_vld_q <= y2_vld_d;
    end
  end

  assign y1     = y1_q;
  assign y2     = y2_q;
  assign y1_vld = y1_vld_q;
  assign y2_vld = y2_vld_q;

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] cnt_y1_q, cnt_y1_d;
  logic [CNT_W-1:0] cnt_y2_q, cnt_y2_d;

  // Count routes per side, saturating at all-ones; clear wins over counting.
  always_comb begin
    cnt_y1_d = cnt_y1_q;
    cnt_y2_d = cnt_y2_q;
    if (cnt_clr) begin
      cnt_y1_d = '0;
      cnt_y2_d = '0;
    end else if (s) begin
      if (cnt_y2_q != '1) cnt_y2_d = cnt_y2_q + CNT_W'(1);
    end else begin
      if (cnt_y1_q != '1) cnt_y1_d = cnt_y1_q + CNT_W'(1);
    end
  end

  // Counter registers; reset has priority over the clear input.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_y1_q <= '0;
      cnt_y2_q <= '0;
    end else begin
      cnt_y1_q <= cnt_y1_d;
      cnt_y2_q <= cnt_y2_d;
    end
  end

  assign cnt_y1 = cnt_y1_q;
  assign cnt_y2 = cnt_y2_q;
`endif

endmodule

// File: tb/tb_demux_1to2.sv
// Self-checking bench for demux_1to2 (WIDTH=8, CNT_W=2). Directed steps
// followed by randomized traffic, compared against a behavioural model.
// Counter checks are active when DEMUX_COUNT_EN is defined.
module tb_demux_1to2;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] i;
  logic             s;
  logic [WIDTH-1:0] y1, y2;
  logic             y1_vld, y2_vld;
`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] cnt_y1, cnt_y2;
  logic             cnt_clr;
  int               m_cnt1, m_cnt2;
`endif

  int checks = 0;
  int failures = 0;

  // Model state: what each output should show after the latest edge.
  int m_y1, m_y2, m_v1, m_v2;

  always #5 clk = ~clk;

  demux_1to2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .i       (i),
    .s       (s),
    .y1      (y1),
    .y2      (y2),
    .y1_vld  (y1_vld),
`ifdef DEMUX_COUNT_EN
    .y2_vld  (y2_vld),
    .cnt_y1  (cnt_y1),
    .cnt_y2  (cnt_y2),
    .cnt_clr (cnt_clr)
`else
    .y2_vld  (y2_vld)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the routing rules,
  // then compare every output shortly after the edge.
  task automatic step(input logic r, input logic [WIDTH-1:0] d, input logic sel,
                      input logic clr, input string tag);
    rst = r;
    i   = d;
    s   = sel;
`ifdef DEMUX_COUNT_EN
    cnt_clr = clr;
`endif
    @(posedge clk);
    if (r) begin
      m_y1 = 0; m_y2 = 0; m_v1 = 0; m_v2 = 0;
`ifdef DEMUX_COUNT_EN
      m_cnt1 = 0; m_cnt2 = 0;
`endif
    end else begin
      m_y1 = sel ? 0 : int'(d);
      m_y2 = sel ? int'(d) : 0;
      m_v1 = sel ? 0 : 1;
      m_v2 = sel ? 1 : 0;
`ifdef DEMUX_COUNT_EN
      if (clr) begin
        m_cnt1 = 0; m_cnt2 = 0;
      end else if (sel) begin
        m_cnt2 = (m_cnt2 < CNT_MAX) ? m_cnt2 + 1 : CNT_MAX;
      end else begin
        m_cnt1 = (m_cnt1 < CNT_MAX) ? m_cnt1 + 1 : CNT_MAX;
      end
`endif
    end
    #1;
    check({tag, ".y1"},     32'(y1),     32'(m_y1));
    check({tag, ".y2"},     32'(y2),     32'(m_y2));
    check({tag, ".y1_vld"}, 32'(y1_vld), 32'(m_v1));
    check({tag, ".y2_vld"}, 32'(y2_vld), 32'(m_v2));
`ifdef DEMUX_COUNT_EN
    check({tag, ".cnt_y1"}, 32'(cnt_y1), 32'(m_cnt1));
    check({tag, ".cnt_y2"}, 32'(cnt_y2), 32'(m_cnt2));
`endif
  endtask

  initial begin
    rst = 1'b1; i = '0; s = 1'b0;
`ifdef DEMUX_COUNT_EN
    cnt_clr = 1'b0;
`endif
    // Reset held two cycles with live inputs present.
    step(1'b1, 8'h01, 1'b1, 1'b0, "rst0");
    step(1'b1, 8'h01, 1'b1, 1'b0, "rst1");
    // Basic routing to each side.
    step(1'b0, 8'h01, 1'b0, 1'b0, "route_y1");
    step(1'b0, 8'h01, 1'b1, 1'b0, "route_y2");
    // Zero data still routes; valid follows select.
    step(1'b0, 8'h00, 1'b0, 1'b0, "zero_y1");
    step(1'b0, 8'h00, 1'b1, 1'b0, "zero_y2");
    // Alternating select with full-width data, then reset mid-stream.
    step(1'b0, 8'hA5, 1'b0, 1'b0, "alt0");
    step(1'b0, 8'hA5, 1'b1, 1'b0, "alt1");
    step(1'b0, 8'hA5, 1'b0, 1'b0, "alt2");
    step(1'b1, 8'hA5, 1'b1, 1'b1, "mid_rst");
    step(1'b0, 8'h5A, 1'b1, 1'b0, "resume");
    // Saturation: five routes to y1 after a reset, then clear.
    step(1'b1, 8'h00, 1'b0, 1'b0, "sat_rst");
    for (int k = 0; k < 5; k++) step(1'b0, 8'(k + 1), 1'b0, 1'b0, "sat_y1");
    step(1'b0, 8'h33, 1'b1, 1'b1, "clr");
    // Randomized traffic with occasional clear and rare reset.
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 19) == 0), 8'($urandom), 1'($urandom),
           ($urandom_range(0, 9) == 0), "rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
